// File: rtl/pwm_duty_responder.sv
// PWM duty-cycle responder: four-phase req/ack capture, glitch-free apply at period wrap.
// Optional two-flop request synchronizer enabled by defining PWM_REQ_SYNC_EN.
module pwm_duty_responder #(
  parameter int DUTY_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tx_req,
  input  logic [DUTY_WIDTH-1:0] duty_in,
  output logic                  tx_ack,
  output logic                  pwm_out,
  output logic [DUTY_WIDTH-1:0] duty_active,
  output logic                  period_start
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  logic req_i;

`ifdef PWM_REQ_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], tx_req};
    end
  end

  assign req_i = sync_q[1];
`else
  assign req_i = tx_req;
`endif

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic [DUTY_WIDTH-1:0] pending_q, pending_d;
  logic [DUTY_WIDTH-1:0] cnt_q, cnt_d;
  logic [DUTY_WIDTH-1:0] active_q, active_d;
  logic                  pwm_q, pwm_d;
  logic                  ps_q, ps_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      pending_q <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      pwm_q     <= 1'b0;
      ps_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
    end
  end

  // A new request is only accepted from IDLE, so a held request never re-captures.
  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          pending_d = duty_in;
          ack_d     = 1'b1;
          state_d   = ACK;
        end
      end
      ACK: begin
        if (!req_i) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Active duty loads the pre-edge pending value, so a capture coinciding with a wrap waits a period.
  always_comb begin
    cnt_d    = cnt_q + DUTY_WIDTH'(1);
    active_d = (cnt_q == {DUTY_WIDTH{1'b1}}) ? pending_q : active_q;
    pwm_d    = (cnt_q < active_q);
    ps_d     = (cnt_d == '0);
  end

  assign tx_ack       = ack_q;
  assign pwm_out      = pwm_q;
  assign duty_active  = active_q;
  assign period_start = ps_q;

endmodule

// File: doc/pwm_duty_responder.md
# pwm_duty_responder

Responder end of the four-phase req/ack handshake that the CPU memory map drives to deliver PWM duty cycles. It sits between the memory-mapped `tx_req` / duty-cycle registers and the speaker pin. It captures a new duty cycle on each request and acknowledges it. It applies the new value glitch-free at the next PWM period boundary and generates the PWM waveform from a free-running counter.

## Interface
- `DUTY_WIDTH`, 12, duty-cycle and PWM counter width. The PWM period is 2^DUTY_WIDTH clocks.
- `clk`  in  1  system clock. All state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_req`  in  1  request from the initiator (memory map). Level signal.
- `duty_in`  in  DUTY_WIDTH  duty cycle. The initiator holds it stable from the `tx_req` rise until it sees `tx_ack` high.
- `tx_ack`  out  1  acknowledge to the initiator. Registered.
- `pwm_out`  out  1  PWM waveform. Registered.
- `duty_active`  out  DUTY_WIDTH  duty cycle currently shaping `pwm_out`.
- `period_start`  out  1  one-cycle pulse in the cycle where the counter equals 0.

## Operation
- Internal request `req_i` equals `tx_req`, or the synchronized copy of it (see Configuration).
- Handshake FSM has two states, IDLE and ACK.
- IDLE with `req_i`=1:
  - capture `duty_in` into `duty_pending`;
  - set `tx_ack`=1;
  - go to ACK.
- ACK with `req_i`=1: hold. No re-capture, `tx_ack` stays 1.
- ACK with `req_i`=0: clear `tx_ack`, go to IDLE.
- The handshake is complete when both signals have returned low. A new request is accepted only from IDLE.
- PWM counter `cnt` (DUTY_WIDTH bits):
  - increments every cycle;
  - wraps from 2^DUTY_WIDTH−1 to 0, with no saturation.
- On the edge where `cnt` wraps to 0, `duty_active` <= `duty_pending`.
- `pwm_out` <= (`cnt` < `duty_active`). The comparison is unsigned and full width.
- Duty 0 gives `pwm_out` constantly low. Duty 2^W−1 gives high for 2^W−1 of every 2^W cycles. 100% is unreachable by design.
- `period_start` = (`cnt` == 0), registered alongside `cnt`.

## Timing
- Reset values, asserted asynchronously while `reset_n`=0:
  - `tx_ack`=0, `pwm_out`=0, `duty_active`=0, `period_start`=0;
  - `cnt`=0, `duty_pending`=0, FSM=IDLE.
- Release of reset takes effect on the first `clk` edge after deassertion.
- Ack latency, `tx_ack` high counted from the first cycle `tx_req` is high:
  - 1 edge without synchronizer;
  - 3 edges with synchronizer.
- Ack drop latency, counted from `tx_req` low: the same 1 or 3 edges.
- Apply latency: the captured duty reaches `duty_active` at the next wrap, so after 1 to 2^W cycles. It affects `pwm_out` one cycle after that.
- Capture on the same edge as a wrap: `duty_active` loads the old `duty_pending`. The new value applies at the following wrap.
- Two handshakes within one period: the last captured value wins. Intermediate values are never applied.
- `tx_req` held high indefinitely: remain in ACK with no further captures.
- Reset mid-handshake:
  - `tx_ack` drops immediately and the FSM returns to IDLE;
  - the pending value is lost;
  - the initiator must deassert `tx_req` and restart.
- Reset does not depend on `clk` running.

## Configuration
- `PWM_REQ_SYNC_EN` defined:
  - `tx_req` passes through a two-flop synchronizer, reset to 0, before `req_i`;
  - ack latencies are 3 edges;
  - use when the requester is in another clock domain.
- `PWM_REQ_SYNC_EN` undefined:
  - `req_i` = `tx_req` directly;
  - ack latencies are 1 edge;
  - no synchronizer flops are present.

## Test plan
- Reset with `reset_n`=0 mid-period, with `tx_ack` high and `cnt`=1000 → all outputs 0 immediately, with no `clk` edge needed. After release, `cnt` counts from 0.
- `duty_in`=0, full handshake → `tx_ack` rises 1 edge (3 with macro) after `tx_req`, and falls the same latency after `tx_req` drops. `pwm_out` stays 0 for two full periods.
- `duty_in`=1024 (W=12) → after the next `period_start`:
  - `pwm_out` high for exactly 1024 cycles, then low for 3072;
  - period is 4096 cycles.
- Handshake completes with `duty_in`=2048 on the same edge as the wrap, with `duty_active`=512 → that period runs at 512. `duty_active`=2048 from the next wrap.
- Two handshakes in one period, 100 then 3000 → `duty_active` goes directly to 3000 at the wrap. 100 is never observed.
- `tx_req` held high for 50 cycles while `duty_in` changes 7→9 after ack → `tx_ack` stays high and only 7 is applied. Deassert `tx_req` → `tx_ack` low, FSM back in IDLE.
